boot_copy_engine: RTL



---
 rtl/boot_copy_engine_pkg.sv | 15 +
 rtl/boot_copy_engine_if.sv | 37 +++
 rtl/boot_copy_engine_checksum.sv | 21 ++
 rtl/boot_copy_engine.sv | 94 +++++++++
 4 files changed

// File: rtl/boot_copy_engine_pkg.sv
// Shared definitions for the boot copy engine: FSM encoding, strobe constant, default RAM base.
// Consumers pull these in with import ricosoc_pkg::*.
package ricosoc_pkg;

    typedef enum logic [1:0] {
        ADDR   = 2'd0,
        FETCH  = 2'd1,
        WRITE  = 2'd2,
        FINISH = 2'd3
    } copy_state_t;

    localparam logic [3:0]  WSTRB_FULL    = 4'hF;
    localparam logic [31:0] BOOT_RAM_BASE = 32'h0000_0000;

endpackage

// File: rtl/boot_copy_engine_if.sv
// ROM read port and picorv32-style native RAM write port used by the boot copy engine.
interface boot_copy_engine_if #(
    parameter int RAM_ADDR_WIDTH = 8,
    parameter int RAM_DATA_WIDTH = 32
);
    logic [RAM_ADDR_WIDTH-1:0] rom_raddr;
    logic [RAM_DATA_WIDTH-1:0] rom_rdata;

    // Write handshake: a write is accepted on a rising clk edge where mem_valid && mem_ready.
    // Once mem_valid rises, mem_addr/mem_wdata/mem_wstrb stay stable until that edge;
    // mem_ready while mem_valid is low has no effect.
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;

    modport master (
        output rom_raddr,
        input  rom_rdata,
        output mem_valid,
        input  mem_ready,
        output mem_addr,
        output mem_wdata,
        output mem_wstrb
    );

    modport slave (
        input  rom_raddr,
        output rom_rdata,
        input  mem_valid,
        output mem_ready,
        input  mem_addr,
        input  mem_wdata,
        input  mem_wstrb
    );
endinterface

// File: rtl/boot_copy_engine_checksum.sv
// Running 32-bit sum of every word written by the copy engine, plus a zero-compare.
// Only instantiated when BOOT_COPY_CHECKSUM_EN is defined.
module boot_copy_checksum (
    input  logic        clk,
    input  logic        reset,
    input  logic        add_en,
    input  logic [31:0] word,
    output logic        sum_zero
);
    logic [31:0] sum;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum <= 32'd0;
        end else if (add_en) begin
            sum <= sum + word;
        end
    end

    assign sum_zero = (sum == 32'd0);
endmodule

// File: rtl/boot_copy_engine.sv
// Copies COPY_WORDS words from the boot ROM into RAM, then releases the CPU from reset.
// Optional image checksum check is enabled with `define BOOT_COPY_CHECKSUM_EN.
module boot_copy_engine
    import ricosoc_pkg::*;
#(
    parameter int          RAM_DATA_WIDTH = 32,
    parameter int          RAM_ADDR_WIDTH = 8,
    parameter int          COPY_WORDS     = 256,
    parameter logic [31:0] DEST_BASE      = BOOT_RAM_BASE
) (
    input  logic                clk,
    input  logic                reset,
    boot_copy_engine_if.master  bus,
    output logic                cpu_resetn,
    output logic                done,
    output logic                boot_error,
    output copy_state_t         dbg_state
);
    localparam int IDX_W = $clog2(COPY_WORDS + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(COPY_WORDS - 1);

    copy_state_t               state;
    logic [IDX_W-1:0]          idx;
    logic [RAM_DATA_WIDTH-1:0] rom_word;
    logic                      handshake;
    logic                      sum_ok;

    assign rom_word  = bus.rom_rdata;
    assign handshake = (state == WRITE) && bus.mem_valid && bus.mem_ready;
    assign dbg_state = state;

`ifdef BOOT_COPY_CHECKSUM_EN
    boot_copy_checksum u_checksum (
        .clk      (clk),
        .reset    (reset),
        .add_en   (handshake),
        .word     (bus.mem_wdata),
        .sum_zero (sum_ok)
    );
`else
    assign sum_ok = 1'b1;
`endif

    // rom_raddr is kept as its own counter; it tracks idx modulo 2**RAM_ADDR_WIDTH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ADDR;
            idx           <= '0;
            bus.rom_raddr <= '0;
            bus.mem_valid <= 1'b0;
            bus.mem_addr  <= DEST_BASE;
            bus.mem_wdata <= 32'd0;
            bus.mem_wstrb <= 4'd0;
            cpu_resetn    <= 1'b0;
            done          <= 1'b0;
            boot_error    <= 1'b0;
        end else begin
            case (state)
                ADDR: begin
                    state <= FETCH;
                end
                FETCH: begin
                    bus.mem_wdata <= rom_word[31:0];
                    bus.mem_addr  <= DEST_BASE + (32'(idx) << 2);
                    bus.mem_valid <= 1'b1;
                    bus.mem_wstrb <= WSTRB_FULL;
                    state         <= WRITE;
                end
                WRITE: begin
                    if (handshake) begin
                        bus.mem_valid <= 1'b0;
                        bus.mem_wstrb <= 4'd0;
                        idx           <= idx + 1'b1;
                        bus.rom_raddr <= bus.rom_raddr + 1'b1;
                        state         <= (idx == LAST_IDX) ? FINISH : ADDR;
                    end
                end
                FINISH: begin
                    done <= 1'b1;
                    if (!sum_ok) begin
                        boot_error <= 1'b1;
                    end
                    // CPU release lags done by one cycle and never happens on a bad image.
                    if (done && sum_ok) begin
                        cpu_resetn <= 1'b1;
                    end
                end
                default: begin
                    state <= ADDR;
                end
            endcase
        end
    end
endmodule
